rps_requester4: RTL
===================

# rps_requester4

Four-client request tracker that sits on the requester side of the 4-way rotating-priority arbiter (`rps4`). It does the following:
- Accepts per-client request pulses and queues them as pending counts.
- Presents the `req[3:0]` vector to the arbiter.
- Consumes the arbiter's `gnt[3:0]` to retire requests.
- Flags protocol violations: non-one-hot grants, grants without a request, and overflow.
- Optionally flags clients that have waited too long for service.

## Interface
- `CNT_W`, default 3: width of each client's pending counter; max pending per client = 2^CNT_W − 1.
- `WAIT_LIMIT`, default 8: number of consecutive un-granted request cycles at which `starve[i]` asserts; legal range 1..255.
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `push`  in  4: bit i = one new request from client i this cycle.
- `gnt`  in  4: grant vector from the arbiter, sampled at the rising edge.
- `req`  out  4: request vector to the arbiter; `req[i] = (pend[i] != 0)`, decoded from registers only, with no combinational path from inputs.
- `pend`  out  4*CNT_W: pending counts; client i occupies bits `[i*CNT_W +: CNT_W]`.
- `full`  out  4: `full[i] = (pend[i] == max)`.
- `done`  out  4: registered one-cycle pulse; bit i asserts the cycle after a grant to client i is accepted.
- `ovf`  out  4: sticky; bit i sets when client i drops a push because it is full.
- `err`  out  1: sticky; sets on any grant-protocol violation.
- `starve`  out  4: bit i asserts while client i's wait count ≥ `WAIT_LIMIT`.

## Operation
Grant acceptance:
- Client i's grant is accepted at an edge when `req[i] & gnt[i] & onehot(gnt)`.

Per-client counter update at each edge:
- Push only: `pend+1`. If `pend` is at max, the count is held and `ovf[i]` sets.
- Accepted grant only: `pend−1`.
- Push and accepted grant together: `pend` is unchanged, and the push is never counted as an overflow.
- Neither: hold.

Protocol checks:
- `gnt` has more than one bit set: no grant is accepted that cycle, all counts hold except for pushes, and `err` sets.
- `gnt[i]=1` with `req[i]=0`: `err` sets. The count does not underflow and stays 0.
- `gnt == 0` is legal. It covers the arbiter being disabled and no state changes result.

Status outputs:
- `done[i]` is registered from the accepted-grant condition.
- `ovf` and `err` clear only on `reset`.

Counter arithmetic:
- Counts are unsigned with no wrap-around: they saturate at max on push and clamp at 0 on grant.

Reset behaviour:
- Reset mid-operation discards all pending requests.
- Every output is 0 during and after reset: `req`, `pend`, `full`, `done`, `ovf`, `err` and `starve`.

## Timing
- A push at edge k makes `req[i]=1` immediately after edge k; latency is 1 edge.
- The arbiter drives `gnt` combinationally in the same cycle. The bench/arbiter must settle `gnt` before the edge.
- A grant accepted at edge k:
  - `pend` decrements after edge k.
  - `req[i]` falls after edge k if the count reaches 0.
  - `done[i]` is high for the cycle following edge k.
- Back-to-back grants to the same client are allowed on consecutive cycles. Throughput is 1 retire per client per cycle.
- `ovf` and `err` assert after the offending edge.
- `starve` is registered; it asserts after the edge at which the wait count reaches `WAIT_LIMIT`.

## Configuration
- `RPS_REQ_STARVE_EN` defined: the starvation monitor is compiled in.
  - Each client has an 8-bit wait counter.
  - The counter increments on each edge where `req[i] & ~accepted[i]`, saturating at `WAIT_LIMIT`.
  - It clears on an accepted grant or when `req[i]=0`.
  - `starve[i] = (wait[i] >= WAIT_LIMIT)`.
- `RPS_REQ_STARVE_EN` undefined: no wait counters are built and `starve` is tied to 4'b0000.

## Test plan
- Reset check: assert `reset` asynchronously mid-cycle with `pend=3` on client 0 -> all outputs 0 immediately; `req=0000` after release.
- Single push and grant: push=0001 for one cycle, then `gnt=0001` -> `req=0001` for exactly one cycle, `done=0001` the following cycle, `pend[0]=0`.
- Round-robin drain:
  - Stimulus: push=1111 once, then `gnt` = 0001, 0010, 0100, 1000 on successive cycles.
  - Required response: `req` goes 1111 -> 1110 -> 1100 -> 1000 -> 0000, and `done` follows one cycle later each step.
- Saturation and simultaneity (`CNT_W=3`):
  - 8 consecutive pushes on client 2 -> `pend[2]=7`, `full[2]=1`, `ovf[2]=1`.
  - Then push and `gnt=0100` in the same cycle -> `pend[2]` stays 7.
  - `ovf` does not clear.
- Protocol errors:
  - `gnt=0011` with `req=0011` -> `err=1` and both counts unchanged.
  - After reset, `gnt=0100` with `req=0000` -> `err=1` and `pend[2]` remains 0.
- Starvation:
  - With `RPS_REQ_STARVE_EN` defined: push client 3, hold `gnt=0000` for 8 cycles -> `starve=1000`; then `gnt=1000` -> `starve=0000` after the edge.
  - Without the macro: `starve=0000` throughout.

Source files
------------

// File: rtl/rps_requester4.sv
// Four-client request tracker feeding the rps4 rotating-priority arbiter.
// Optional starvation monitor: define RPS_REQ_STARVE_EN to build per-client wait counters.

module rps_req_lane #(
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             acc,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             done,
    output logic             ovf
);
    localparam logic [CNT_W-1:0] MAX = '1;

    assign full = (cnt == MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            done <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            done <= acc;
            // A push that coincides with a retire cancels out and can never overflow.
            if (push && !acc) begin
                if (cnt == MAX) ovf <= 1'b1;
                else            cnt <= cnt + CNT_W'(1);
            end else if (acc && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end
endmodule

module rps_requester4 #(
    parameter int CNT_W      = 3,
    parameter int WAIT_LIMIT = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         push,
    input  logic [3:0]         gnt,
    output logic [3:0]         req,
    output logic [4*CNT_W-1:0] pend,
    output logic [3:0]         full,
    output logic [3:0]         done,
    output logic [3:0]         ovf,
    output logic               err,
    output logic [3:0]         starve
);
    logic [3:0][CNT_W-1:0] cnt;
    logic                  gnt_onehot;
    logic                  gnt_multi;
    logic [3:0]            acc;

    assign gnt_onehot = (gnt != 4'd0) && ((gnt & (gnt - 4'd1)) == 4'd0);
    assign gnt_multi  = (gnt != 4'd0) && !gnt_onehot;
    assign acc        = req & gnt & {4{gnt_onehot}};
    assign pend       = cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                          err <= 1'b0;
        else if (gnt_multi || |(gnt & ~req)) err <= 1'b1;
    end

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_lane
            rps_req_lane #(.CNT_W(CNT_W)) u_lane (
                .clock (clock),
                .reset (reset),
                .push  (push[i]),
                .acc   (acc[i]),
                .cnt   (cnt[i]),
                .full  (full[i]),
                .done  (done[i]),
                .ovf   (ovf[i])
            );
            assign req[i] = (cnt[i] != '0);

`ifdef RPS_REQ_STARVE_EN
            localparam logic [7:0] LIM = 8'(WAIT_LIMIT);
            logic [7:0] wait_cnt;

            always_ff @(posedge clock or posedge reset) begin
                if (reset)                  wait_cnt <= 8'd0;
                else if (acc[i] || !req[i]) wait_cnt <= 8'd0;
                else if (wait_cnt < LIM)    wait_cnt <= wait_cnt + 8'd1;
            end
            assign starve[i] = (wait_cnt >= LIM);
`else
            // Monitor not built; the term is constant 0 for any legal limit.
            assign starve[i] = (WAIT_LIMIT < 1);
`endif
        end
    endgenerate
endmodule
